// File: rtl/segment_transition_ctl_pkg.sv
// Shared types for the segment transition controller.
// Mode encodings match the existing controller register map.
package segment_transition_ctl_pkg;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_STOPPED
  } seg_state_t;

  localparam int DefNumSegment = 2;
  localparam logic [15:0] RepInfinite = 16'hFFFF;

  function automatic logic mode_known(
    input logic [7:0] m
  );
    return m inside {
      MODE_SYNC_IDX, MODE_SYS_TIME,
      MODE_GPIO, MODE_EXT
    };
  endfunction

endpackage

// File: rtl/segment_transition_ctl_if.sv
// Request/status bundle between register decoder,
// transition controller and the index timers.
interface segment_transition_ctl_if #(
  parameter int NumSegment = 2,
  parameter int IdxWidth   = 16,
  parameter int RepWidth   = 16,
  parameter int TimeWidth  = 64,
  parameter int NumGpio    = 4
);
  localparam int SegW =
    (NumSegment > 1) ? $clog2(NumSegment) : 1;

  logic                           update;
  logic [SegW-1:0]                req_segment;
  logic [RepWidth-1:0]            req_rep;
  logic [7:0]                     transition_mode;
  logic [TimeWidth-1:0]           transition_value;
  logic [NumSegment*IdxWidth-1:0] cycle;
  logic [IdxWidth-1:0]            idx;
  logic [TimeWidth-1:0]           sys_time;
  logic [NumGpio-1:0]             gpio_in;
  logic [SegW-1:0]                segment;
  logic                           swap;
  logic                           stop;
  logic                           pending;
  logic                           req_err;

  modport master (
    output update, req_segment, req_rep,
    output transition_mode, transition_value,
    output cycle, idx, sys_time, gpio_in,
    input  segment, swap, stop, pending, req_err
  );

  modport slave (
    input  update, req_segment, req_rep,
    input  transition_mode, transition_value,
    input  cycle, idx, sys_time, gpio_in,
    output segment, swap, stop, pending, req_err
  );

endinterface

// File: rtl/segment_transition_ctl_edge_det_sel.sv
// Rising-edge detector over a GPIO vector with
// a run-time index select of the edge to report.
module edge_det_sel #(
  parameter int N    = 4,
  parameter int SelW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_in,
  input  logic [SelW-1:0] i_sel,
  output logic            o_rise
);

  logic [N-1:0]         r_prev;
  logic [N-1:0]         w_rise;
  logic [2**SelW-1:0]   w_pad;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= '0;
    else       r_prev <= i_in;
  end

  // Zero-pad so any select value is in range.
  assign w_rise = i_in & ~r_prev;
  assign w_pad  = (2**SelW)'(w_rise);
  assign o_rise = w_pad[i_sel];

endmodule

// File: rtl/segment_transition_ctl.sv
// Segment swap controller: latches a request, waits for
// its transition condition, counts loops, round-robins.
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter int NumSegment = DefNumSegment,
  parameter int IdxWidth   = 16,
  parameter int RepWidth   = $bits(RepInfinite),
  parameter int TimeWidth  = 64,
  parameter int NumGpio    = 4
) (
  input logic i_clk,
  input logic i_rst,
  segment_transition_ctl_if.slave bus
);

  localparam int SegW =
    (NumSegment > 1) ? $clog2(NumSegment) : 1;
  localparam int GpioW =
    (NumGpio > 1) ? $clog2(NumGpio) : 1;
  localparam logic [RepWidth-1:0] RepInf = '1;
  localparam logic [SegW-1:0] SegLast =
    SegW'(NumSegment - 1);

  seg_state_t           r_state, w_state_nxt;
  logic [SegW-1:0]      r_segment, w_seg_nxt;
  logic                 r_swap, w_swap_nxt;
  logic                 r_stop, w_stop_nxt;
  logic                 r_req_err, w_err_nxt;
  logic [RepWidth-1:0]  r_cnt, w_cnt_nxt;
  logic [RepWidth-1:0]  r_rep, w_rep_nxt;
  logic                 r_ext, w_ext_nxt;
  logic [SegW-1:0]      r_req_seg, w_req_seg_nxt;
  logic [RepWidth-1:0]  r_req_rep, w_req_rep_nxt;
  transition_mode_t     r_mode, w_mode_nxt;
  logic [TimeWidth-1:0] r_value, w_value_nxt;

  logic                 w_seg_ok;
  logic                 w_upd_ok;
  logic                 w_upd_bad;
  logic [IdxWidth-1:0]  w_cyc_cur;
  logic                 w_wrap;
  logic                 w_rise;
  logic                 w_cond;
  logic [SegW-1:0]      w_seg_inc;

  edge_det_sel #(
    .N    (NumGpio),
    .SelW (GpioW)
  ) u_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_in   (bus.gpio_in),
    .i_sel  (r_value[GpioW-1:0]),
    .o_rise (w_rise)
  );

  assign w_seg_ok =
    32'(bus.req_segment) < NumSegment;
  assign w_upd_ok = bus.update & w_seg_ok &
    mode_known(bus.transition_mode);
  assign w_upd_bad = bus.update & ~w_upd_ok;

  assign w_cyc_cur =
    bus.cycle[32'(r_segment)*IdxWidth +: IdxWidth];
  assign w_wrap = (bus.idx == w_cyc_cur);
  assign w_seg_inc = (r_segment == SegLast) ?
    '0 : r_segment + 1'b1;

  // A held timer (STOP) never wraps again, so sync is immediate.
  always_comb begin
    w_cond = 1'b0;
    unique case (r_mode)
      MODE_SYNC_IDX: w_cond = r_stop | w_wrap;
      MODE_SYS_TIME: w_cond = bus.sys_time >= r_value;
      MODE_GPIO:     w_cond = w_rise;
      MODE_EXT:      w_cond = 1'b1;
      default:       w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_seg_nxt     = r_segment;
    w_swap_nxt    = 1'b0;
    w_stop_nxt    = r_stop;
    w_err_nxt     = r_req_err;
    w_cnt_nxt     = r_cnt;
    w_rep_nxt     = r_rep;
    w_ext_nxt     = r_ext;
    w_req_seg_nxt = r_req_seg;
    w_req_rep_nxt = r_req_rep;
    w_mode_nxt    = r_mode;
    w_value_nxt   = r_value;
    if (w_upd_ok) begin
      w_state_nxt   = ST_WAIT;
      w_err_nxt     = 1'b0;
      w_ext_nxt     = 1'b0;
      w_req_seg_nxt = bus.req_segment;
      w_req_rep_nxt = bus.req_rep;
      w_mode_nxt    =
        transition_mode_t'(bus.transition_mode);
      w_value_nxt   = bus.transition_value;
    end else begin
      if (w_upd_bad) w_err_nxt = 1'b1;
      unique case (r_state)
        ST_RUN: begin
          if (w_wrap && r_rep != RepInf) begin
            if (r_cnt != r_rep) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end else if (r_ext) begin
              w_seg_nxt  = w_seg_inc;
              w_swap_nxt = 1'b1;
              w_cnt_nxt  = '0;
            end else begin
              w_state_nxt = ST_STOPPED;
              w_stop_nxt  = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (w_cond) begin
            w_state_nxt = ST_RUN;
            w_seg_nxt   = r_req_seg;
            w_swap_nxt  = 1'b1;
            w_stop_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_rep_nxt   = r_req_rep;
            w_ext_nxt   = (r_mode == MODE_EXT);
          end
        end
        ST_STOPPED: begin
          w_state_nxt = ST_STOPPED;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_RUN;
      r_segment <= '0;
      r_swap    <= 1'b0;
      r_stop    <= 1'b0;
      r_req_err <= 1'b0;
      r_cnt     <= '0;
      r_rep     <= RepInf;
      r_ext     <= 1'b0;
      r_req_seg <= '0;
      r_req_rep <= RepInf;
      r_mode    <= MODE_SYNC_IDX;
      r_value   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_segment <= w_seg_nxt;
      r_swap    <= w_swap_nxt;
      r_stop    <= w_stop_nxt;
      r_req_err <= w_err_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rep     <= w_rep_nxt;
      r_ext     <= w_ext_nxt;
      r_req_seg <= w_req_seg_nxt;
      r_req_rep <= w_req_rep_nxt;
      r_mode    <= w_mode_nxt;
      r_value   <= w_value_nxt;
    end
  end

  assign bus.segment = r_segment;
  assign bus.swap    = r_swap;
  assign bus.stop    = r_stop;
  assign bus.pending = (r_state == ST_WAIT);
  assign bus.req_err = r_req_err;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl with five
// segments and a small index-timer model driving IDX.
module tb_segment_transition_ctl;
  import segment_transition_ctl_pkg::*;

  localparam int NS = 5;
  localparam int IW = 16;
  localparam int RW = 16;
  localparam int TW = 64;
  localparam int NG = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  segment_transition_ctl_if #(
    .NumSegment(NS), .IdxWidth(IW), .RepWidth(RW),
    .TimeWidth(TW), .NumGpio(NG)
  ) bus ();

  segment_transition_ctl #(
    .NumSegment(NS), .IdxWidth(IW), .RepWidth(RW),
    .TimeWidth(TW), .NumGpio(NG)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [IW-1:0] cyc [NS];
  always_comb
    for (int i = 0; i < NS; i++)
      bus.cycle[i*IW +: IW] = cyc[i];

  typedef struct {
    logic [2:0] seg;
    logic [7:0] mode;
    logic       exp_err;
    logic       exp_pend;
  } vec_t;

  vec_t tv [6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  // Timer model: IDX is 0 in the SWAP cycle, held at CYCLE on STOP.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.swap) bus.idx = '0;
    else if (bus.stop) bus.idx = cyc[bus.segment];
    else if (bus.idx == cyc[bus.segment]) bus.idx = '0;
    else bus.idx = bus.idx + 1'b1;
    bus.sys_time = bus.sys_time + 1;
  endtask

  task automatic upd(input logic [2:0]  seg,
                     input logic [7:0]  mode,
                     input logic [15:0] rep,
                     input logic [63:0] val);
    bus.update           = 1'b1;
    bus.req_segment      = seg;
    bus.transition_mode  = mode;
    bus.req_rep          = rep;
    bus.transition_value = val;
    step();
    bus.update = 1'b0;
  endtask

  task automatic wait_swap(output int n, input int lim);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.swap && n < lim);
  endtask

  initial begin
    int n;
    logic sw;
    logic [2:0] rr [4];

    tv[0] = '{3'd5, MODE_SYNC_IDX, 1'b1, 1'b0};
    tv[1] = '{3'd1, 8'h07,         1'b1, 1'b0};
    tv[2] = '{3'd2, MODE_SYNC_IDX, 1'b0, 1'b1};
    tv[3] = '{3'd6, MODE_SYNC_IDX, 1'b1, 1'b1};
    tv[4] = '{3'd4, MODE_GPIO,     1'b0, 1'b1};
    tv[5] = '{3'd0, 8'hFF,         1'b1, 1'b1};
    rr[0] = 3'd2; rr[1] = 3'd3;
    rr[2] = 3'd4; rr[3] = 3'd0;

    for (int i = 0; i < NS; i++) cyc[i] = 16'd200;
    bus.update = 1'b0;
    bus.req_segment = '0;
    bus.req_rep = '0;
    bus.transition_mode = '0;
    bus.transition_value = '0;
    bus.idx = '0;
    bus.sys_time = '0;
    bus.gpio_in = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus.idx = '0;
    chk("rst segment", bus.segment, 0);
    chk("rst swap", bus.swap, 0);
    chk("rst stop", bus.stop, 0);
    chk("rst pending", bus.pending, 0);
    chk("rst req_err", bus.req_err, 0);

    for (int i = 0; i < 6; i++) begin
      upd(tv[i].seg, tv[i].mode, 16'hFFFF, 64'd0);
      chk($sformatf("vec%0d req_err", i),
          bus.req_err, tv[i].exp_err);
      chk($sformatf("vec%0d pending", i),
          bus.pending, tv[i].exp_pend);
      chk($sformatf("vec%0d segment", i),
          bus.segment, 0);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc[0] = 16'd9;
    cyc[1] = 16'd9;
    bus.idx = '0;

    // SYNC_IDX: request at IDX 3, swap after IDX 9.
    for (int k = 0; k < 20 && bus.idx != 3; k++) step();
    upd(3'd1, MODE_SYNC_IDX, 16'hFFFF, 64'd0);
    chk("sync pending", bus.pending, 1);
    chk("sync early swap", bus.swap, 0);
    wait_swap(n, 30);
    chk("sync swap", bus.swap, 1);
    chk("sync latency", n, 6);
    chk("sync segment", bus.segment, 1);
    chk("sync pending clr", bus.pending, 0);
    step();
    chk("sync swap pulse", bus.swap, 0);

    // SYS_TIME ramp and past target.
    bus.sys_time = 64'd990;
    upd(3'd0, MODE_SYS_TIME, 16'hFFFF, 64'd1000);
    wait_swap(n, 30);
    chk("time swap", bus.swap, 1);
    chk("time at swap", bus.sys_time, 1001);
    chk("time segment", bus.segment, 0);
    upd(3'd1, MODE_SYS_TIME, 16'hFFFF, 64'd500);
    chk("past pending", bus.pending, 1);
    chk("past no swap", bus.swap, 0);
    step();
    chk("past swap", bus.swap, 1);
    chk("past segment", bus.segment, 1);

    // GPIO: edge with UPDATE ignored, wrong pin ignored.
    bus.gpio_in = 4'b0100;
    upd(3'd0, MODE_GPIO, 16'hFFFF, 64'd2);
    sw = 1'b0;
    repeat (3) begin step(); sw |= bus.swap; end
    bus.gpio_in = 4'b0000; step(); sw |= bus.swap;
    bus.gpio_in = 4'b0010; step(); sw |= bus.swap;
    bus.gpio_in = 4'b0000; step(); sw |= bus.swap;
    step(); sw |= bus.swap;
    chk("gpio no swap", sw, 0);
    chk("gpio pending", bus.pending, 1);
    bus.gpio_in = 4'b0100;
    step();
    chk("gpio swap", bus.swap, 1);
    chk("gpio segment", bus.segment, 0);
    bus.gpio_in = 4'b0000;

    // Finite REP=2 on CYCLE=4: 3 loops then STOP.
    cyc[0] = 16'd4;
    upd(3'd0, MODE_SYNC_IDX, 16'd2, 64'd0);
    wait_swap(n, 20);
    chk("fin swap", bus.swap, 1);
    n = 0;
    do begin step(); n++; end
    while (!bus.stop && n < 40);
    chk("fin stop", bus.stop, 1);
    chk("fin stop cycles", n, 15);
    repeat (3) step();
    chk("fin stop held", bus.stop, 1);
    chk("fin seg held", bus.segment, 0);
    chk("fin no swap", bus.swap, 0);
    upd(3'd1, MODE_SYNC_IDX, 16'hFFFF, 64'd0);
    chk("restart pending", bus.pending, 1);
    chk("restart stop kept", bus.stop, 1);
    step();
    chk("restart swap", bus.swap, 1);
    chk("restart segment", bus.segment, 1);
    chk("restart stop clr", bus.stop, 0);

    // EXT round-robin with REP=0.
    for (int i = 0; i < NS; i++) cyc[i] = 16'd4;
    upd(3'd1, MODE_EXT, 16'd0, 64'd0);
    chk("ext pending", bus.pending, 1);
    step();
    chk("ext swap", bus.swap, 1);
    chk("ext segment", bus.segment, 1);
    for (int i = 0; i < 4; i++) begin
      wait_swap(n, 20);
      chk($sformatf("rr%0d segment", i),
          bus.segment, rr[i]);
      chk($sformatf("rr%0d cycles", i), n, 5);
      chk($sformatf("rr%0d stop", i), bus.stop, 0);
    end
    upd(3'd5, MODE_EXT, 16'd0, 64'd0);
    chk("bad seg req_err", bus.req_err, 1);
    chk("bad seg pending", bus.pending, 0);
    chk("bad seg segment", bus.segment, 0);
    wait_swap(n, 20);
    chk("rr after bad", bus.segment, 1);

    // Reset while a request is pending.
    upd(3'd2, MODE_SYS_TIME, 16'hFFFF,
        bus.sys_time + 64'd100);
    chk("rst-wait pending", bus.pending, 1);
    chk("rst-wait err clr", bus.req_err, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2 segment", bus.segment, 0);
    chk("rst2 swap", bus.swap, 0);
    chk("rst2 stop", bus.stop, 0);
    chk("rst2 pending", bus.pending, 0);
    chk("rst2 req_err", bus.req_err, 0);
    sw = 1'b0;
    repeat (150) begin step(); sw |= bus.swap; end
    chk("rst2 no swap", sw, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
